axi_lite_xbar_2x2: RTL and testbench

- Two-master, two-slave AXI4-Lite interconnect between two AXI4-Lite master engines and two register-file slaves.
- Arbitrates each master's read and write requests independently, decodes addresses to a slave, and routes responses back to the requester.
- Decode misses are answered locally with DECERR.

---
 rtl/axi_lite_pkg.sv | 30 +++
 rtl/axi_lite_rr_arb2.sv | 24 ++
 rtl/axi_lite_xbar_2x2.sv | 274 +++++++++++++++++++++++++++
 tb/tb_axi_lite_xbar_2x2.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared AXI4-Lite types, response codes, FSM states and default address map
// Ports: none (package)
package axi_lite_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;

    localparam logic [31:0] DEF_S0_BASE = 32'h0000_0000;
    localparam logic [31:0] DEF_S1_BASE = 32'h0000_1000;
    localparam logic [31:0] DEF_S_SIZE  = 32'h0000_1000;

    typedef logic [AXI_ADDR_W-1:0]   addr_t;
    typedef logic [AXI_DATA_W-1:0]   data_t;
    typedef logic [AXI_DATA_W/8-1:0] strb_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

    typedef struct packed {
        logic miss;
        logic sl;
    } tgt_t;

endpackage

// File: rtl/axi_lite_rr_arb2.sv
// axi_lite_rr_arb2: two-requester round-robin arbiter, master 0 favoured after reset
// Ports: clk, rst (async, active-high); req[1:0] requests; adv strobes completion of the
//        transaction owned by win; gnt is the index of the requester to serve next
module axi_lite_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    input  logic       win,
    output logic       gnt
);

    logic last;

    assign gnt = &req ? ~last : req[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last <= 1'b1;
        else if (adv)
            last <= win;
    end

endmodule

// File: rtl/axi_lite_xbar_2x2.sv
// axi_lite_xbar_2x2: two-master / two-slave AXI4-Lite crossbar with independent read and write paths
// Ports: aclk, areset (async, active-high)
//        m0_*/m1_*: AXI4-Lite slave interfaces facing the masters (AW, W, B, AR, R)
//        s0_*/s1_*: AXI4-Lite master interfaces facing the slaves (AW, W, B, AR, R)
//        Unmapped addresses are answered locally with DECERR.
module axi_lite_xbar_2x2
    import axi_lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] S0_BASE    = ADDR_WIDTH'(DEF_S0_BASE),
    parameter logic [ADDR_WIDTH-1:0] S1_BASE    = ADDR_WIDTH'(DEF_S1_BASE),
    parameter logic [ADDR_WIDTH-1:0] S_SIZE     = ADDR_WIDTH'(DEF_S_SIZE)
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [ADDR_WIDTH-1:0]   m0_awaddr,
    input  logic                    m0_awvalid,
    output logic                    m0_awready,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
    input  logic                    m0_wvalid,
    output logic                    m0_wready,
    output logic [1:0]              m0_bresp,
    output logic                    m0_bvalid,
    input  logic                    m0_bready,
    input  logic [ADDR_WIDTH-1:0]   m0_araddr,
    input  logic                    m0_arvalid,
    output logic                    m0_arready,
    output logic [DATA_WIDTH-1:0]   m0_rdata,
    output logic [1:0]              m0_rresp,
    output logic                    m0_rvalid,
    input  logic                    m0_rready,
    input  logic [ADDR_WIDTH-1:0]   m1_awaddr,
    input  logic                    m1_awvalid,
    output logic                    m1_awready,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
    input  logic                    m1_wvalid,
    output logic                    m1_wready,
    output logic [1:0]              m1_bresp,
    output logic                    m1_bvalid,
    input  logic                    m1_bready,
    input  logic [ADDR_WIDTH-1:0]   m1_araddr,
    input  logic                    m1_arvalid,
    output logic                    m1_arready,
    output logic [DATA_WIDTH-1:0]   m1_rdata,
    output logic [1:0]              m1_rresp,
    output logic                    m1_rvalid,
    input  logic                    m1_rready,
    output logic [ADDR_WIDTH-1:0]   s0_awaddr,
    output logic                    s0_awvalid,
    input  logic                    s0_awready,
    output logic [DATA_WIDTH-1:0]   s0_wdata,
    output logic [DATA_WIDTH/8-1:0] s0_wstrb,
    output logic                    s0_wvalid,
    input  logic                    s0_wready,
    input  logic [1:0]              s0_bresp,
    input  logic                    s0_bvalid,
    output logic                    s0_bready,
    output logic [ADDR_WIDTH-1:0]   s0_araddr,
    output logic                    s0_arvalid,
    input  logic                    s0_arready,
    input  logic [DATA_WIDTH-1:0]   s0_rdata,
    input  logic [1:0]              s0_rresp,
    input  logic                    s0_rvalid,
    output logic                    s0_rready,
    output logic [ADDR_WIDTH-1:0]   s1_awaddr,
    output logic                    s1_awvalid,
    input  logic                    s1_awready,
    output logic [DATA_WIDTH-1:0]   s1_wdata,
    output logic [DATA_WIDTH/8-1:0] s1_wstrb,
    output logic                    s1_wvalid,
    input  logic                    s1_wready,
    input  logic [1:0]              s1_bresp,
    input  logic                    s1_bvalid,
    output logic                    s1_bready,
    output logic [ADDR_WIDTH-1:0]   s1_araddr,
    output logic                    s1_arvalid,
    input  logic                    s1_arready,
    input  logic [DATA_WIDTH-1:0]   s1_rdata,
    input  logic [1:0]              s1_rresp,
    input  logic                    s1_rvalid,
    output logic                    s1_rready
);

    localparam int SW = DATA_WIDTH / 8;

    logic [1:0][ADDR_WIDTH-1:0] m_awaddr, m_araddr, s_awaddr, s_araddr;
    logic [1:0][DATA_WIDTH-1:0] m_wdata, m_rdata, s_wdata, s_rdata;
    logic [1:0][SW-1:0]         m_wstrb, s_wstrb;
    logic [1:0][1:0]            m_bresp, m_rresp, s_bresp, s_rresp;
    logic [1:0] m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [1:0] m_arvalid, m_arready, m_rvalid, m_rready;
    logic [1:0] s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [1:0] s_arvalid, s_arready, s_rvalid, s_rready;

    assign m_awaddr  = {m1_awaddr, m0_awaddr};
    assign m_awvalid = {m1_awvalid, m0_awvalid};
    assign m_wdata   = {m1_wdata, m0_wdata};
    assign m_wstrb   = {m1_wstrb, m0_wstrb};
    assign m_wvalid  = {m1_wvalid, m0_wvalid};
    assign m_bready  = {m1_bready, m0_bready};
    assign m_araddr  = {m1_araddr, m0_araddr};
    assign m_arvalid = {m1_arvalid, m0_arvalid};
    assign m_rready  = {m1_rready, m0_rready};
    assign s_awready = {s1_awready, s0_awready};
    assign s_wready  = {s1_wready, s0_wready};
    assign s_bresp   = {s1_bresp, s0_bresp};
    assign s_bvalid  = {s1_bvalid, s0_bvalid};
    assign s_arready = {s1_arready, s0_arready};
    assign s_rdata   = {s1_rdata, s0_rdata};
    assign s_rresp   = {s1_rresp, s0_rresp};
    assign s_rvalid  = {s1_rvalid, s0_rvalid};

    assign {m1_awready, m0_awready} = m_awready;
    assign {m1_wready, m0_wready}   = m_wready;
    assign {m1_bresp, m0_bresp}     = m_bresp;
    assign {m1_bvalid, m0_bvalid}   = m_bvalid;
    assign {m1_arready, m0_arready} = m_arready;
    assign {m1_rdata, m0_rdata}     = m_rdata;
    assign {m1_rresp, m0_rresp}     = m_rresp;
    assign {m1_rvalid, m0_rvalid}   = m_rvalid;
    assign {s1_awaddr, s0_awaddr}   = s_awaddr;
    assign {s1_awvalid, s0_awvalid} = s_awvalid;
    assign {s1_wdata, s0_wdata}     = s_wdata;
    assign {s1_wstrb, s0_wstrb}     = s_wstrb;
    assign {s1_wvalid, s0_wvalid}   = s_wvalid;
    assign {s1_bready, s0_bready}   = s_bready;
    assign {s1_araddr, s0_araddr}   = s_araddr;
    assign {s1_arvalid, s0_arvalid} = s_arvalid;
    assign {s1_rready, s0_rready}   = s_rready;

    function automatic tgt_t decode(input logic [ADDR_WIDTH-1:0] a);
        if (a >= S0_BASE && a - S0_BASE < S_SIZE)
            return '{miss: 1'b0, sl: 1'b0};
        if (a >= S1_BASE && a - S1_BASE < S_SIZE)
            return '{miss: 1'b0, sl: 1'b1};
        return '{miss: 1'b1, sl: 1'b0};
    endfunction

    w_state_t w_st, w_nxt;
    tgt_t     w_tgt;
    logic     w_id, w_gnt, aw_done, w_done, aw_rdy, w_rdy, aw_hs, w_hs, b_vld, b_hs;

    // On a decode miss the crossbar itself plays the slave: ready once per channel, then DECERR.
    assign aw_rdy = ~aw_done & (w_tgt.miss | s_awready[w_tgt.sl]);
    assign w_rdy  = ~w_done & (w_tgt.miss | s_wready[w_tgt.sl]);
    assign aw_hs  = (w_st == W_FWD) & m_awvalid[w_id] & aw_rdy;
    assign w_hs   = (w_st == W_FWD) & m_wvalid[w_id] & w_rdy;
    assign b_vld  = w_tgt.miss | s_bvalid[w_tgt.sl];
    assign b_hs   = (w_st == W_RESP) & b_vld & m_bready[w_id];

    axi_lite_rr_arb2 u_warb (
        .clk (aclk),
        .rst (areset),
        .req (m_awvalid),
        .adv (b_hs),
        .win (w_id),
        .gnt (w_gnt)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_st    <= W_IDLE;
            w_id    <= 1'b0;
            w_tgt   <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            w_st <= w_nxt;
            if (w_st == W_IDLE) begin
                w_id    <= w_gnt;
                w_tgt   <= decode(m_awaddr[w_gnt]);
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                aw_done <= aw_done | aw_hs;
                w_done  <= w_done | w_hs;
            end
        end
    end

    always_comb begin
        w_nxt = (w_st == W_IDLE && |m_awvalid) ? W_FWD :
                (w_st == W_FWD && (aw_done | aw_hs) && (w_done | w_hs)) ? W_RESP :
                (w_st == W_RESP && b_hs) ? W_IDLE : w_st;
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        m_bresp   = '0;
        s_awvalid = '0;
        s_awaddr  = '0;
        s_wvalid  = '0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_bready  = '0;
        if (w_st == W_FWD) begin
            m_awready[w_id] = aw_rdy;
            m_wready[w_id]  = w_rdy;
            if (!w_tgt.miss) begin
                s_awvalid[w_tgt.sl] = m_awvalid[w_id] & ~aw_done;
                s_awaddr[w_tgt.sl]  = m_awaddr[w_id];
                s_wvalid[w_tgt.sl]  = m_wvalid[w_id] & ~w_done;
                s_wdata[w_tgt.sl]   = m_wdata[w_id];
                s_wstrb[w_tgt.sl]   = m_wstrb[w_id];
            end
        end
        if (w_st == W_RESP) begin
            m_bvalid[w_id]     = b_vld;
            m_bresp[w_id]      = w_tgt.miss ? 2'(DECERR) : s_bresp[w_tgt.sl];
            s_bready[w_tgt.sl] = m_bready[w_id] & ~w_tgt.miss;
        end
    end

    r_state_t r_st, r_nxt;
    tgt_t     r_tgt;
    logic     r_id, r_gnt, ar_rdy, ar_hs, r_vld, r_hs;

    assign ar_rdy = r_tgt.miss | s_arready[r_tgt.sl];
    assign ar_hs  = (r_st == R_ADDR) & m_arvalid[r_id] & ar_rdy;
    assign r_vld  = r_tgt.miss | s_rvalid[r_tgt.sl];
    assign r_hs   = (r_st == R_DATA) & r_vld & m_rready[r_id];

    axi_lite_rr_arb2 u_rarb (
        .clk (aclk),
        .rst (areset),
        .req (m_arvalid),
        .adv (r_hs),
        .win (r_id),
        .gnt (r_gnt)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_st  <= R_IDLE;
            r_id  <= 1'b0;
            r_tgt <= '0;
        end else begin
            r_st <= r_nxt;
            if (r_st == R_IDLE) begin
                r_id  <= r_gnt;
                r_tgt <= decode(m_araddr[r_gnt]);
            end
        end
    end

    always_comb begin
        r_nxt = (r_st == R_IDLE && |m_arvalid) ? R_ADDR :
                (r_st == R_ADDR && ar_hs) ? R_DATA :
                (r_st == R_DATA && r_hs) ? R_IDLE : r_st;
        m_arready = '0;
        m_rvalid  = '0;
        m_rdata   = '0;
        m_rresp   = '0;
        s_arvalid = '0;
        s_araddr  = '0;
        s_rready  = '0;
        if (r_st == R_ADDR) begin
            m_arready[r_id] = ar_rdy;
            if (!r_tgt.miss) begin
                s_arvalid[r_tgt.sl] = m_arvalid[r_id];
                s_araddr[r_tgt.sl]  = m_araddr[r_id];
            end
        end
        if (r_st == R_DATA) begin
            m_rvalid[r_id]     = r_vld;
            m_rdata[r_id]      = r_tgt.miss ? '0 : s_rdata[r_tgt.sl];
            m_rresp[r_id]      = r_tgt.miss ? 2'(DECERR) : s_rresp[r_tgt.sl];
            s_rready[r_tgt.sl] = m_rready[r_id] & ~r_tgt.miss;
        end
    end

endmodule

// File: tb/tb_axi_lite_xbar_2x2.sv
// tb_axi_lite_xbar_2x2: directed self-checking bench with two zero-wait register-file slaves
module tb_axi_lite_xbar_2x2;

    logic aclk, areset;

    logic [31:0] m_awaddr[2], m_wdata[2], m_araddr[2];
    logic [3:0]  m_wstrb[2];
    logic        m_awvalid[2], m_wvalid[2], m_bready[2], m_arvalid[2], m_rready[2];
    logic        m_awready[2], m_wready[2], m_bvalid[2], m_arready[2], m_rvalid[2];
    logic [1:0]  m_bresp[2], m_rresp[2];
    logic [31:0] m_rdata[2];

    logic [31:0] s_awaddr[2], s_wdata[2], s_araddr[2], s_rdata[2];
    logic [3:0]  s_wstrb[2];
    logic        s_awvalid[2], s_wvalid[2], s_bready[2], s_arvalid[2], s_rready[2];
    logic        s_bvalid[2], s_rvalid[2];

    logic [31:0] mem[2][16];
    logic        aw_got[2], w_got[2];
    logic [31:0] aw_a[2], w_d[2];
    int          aw_cnt[2] = '{0, 0};
    int          w_cnt[2]  = '{0, 0};
    int          ar_cnt[2] = '{0, 0};
    logic [31:0] last_aw[2], last_wd[2];

    int n_chk = 0;
    int n_pass = 0;

    axi_lite_xbar_2x2 dut (
        .aclk(aclk), .areset(areset),
        .m0_awaddr(m_awaddr[0]), .m0_awvalid(m_awvalid[0]), .m0_awready(m_awready[0]),
        .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]), .m0_wvalid(m_wvalid[0]), .m0_wready(m_wready[0]),
        .m0_bresp(m_bresp[0]), .m0_bvalid(m_bvalid[0]), .m0_bready(m_bready[0]),
        .m0_araddr(m_araddr[0]), .m0_arvalid(m_arvalid[0]), .m0_arready(m_arready[0]),
        .m0_rdata(m_rdata[0]), .m0_rresp(m_rresp[0]), .m0_rvalid(m_rvalid[0]), .m0_rready(m_rready[0]),
        .m1_awaddr(m_awaddr[1]), .m1_awvalid(m_awvalid[1]), .m1_awready(m_awready[1]),
        .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]), .m1_wvalid(m_wvalid[1]), .m1_wready(m_wready[1]),
        .m1_bresp(m_bresp[1]), .m1_bvalid(m_bvalid[1]), .m1_bready(m_bready[1]),
        .m1_araddr(m_araddr[1]), .m1_arvalid(m_arvalid[1]), .m1_arready(m_arready[1]),
        .m1_rdata(m_rdata[1]), .m1_rresp(m_rresp[1]), .m1_rvalid(m_rvalid[1]), .m1_rready(m_rready[1]),
        .s0_awaddr(s_awaddr[0]), .s0_awvalid(s_awvalid[0]), .s0_awready(1'b1),
        .s0_wdata(s_wdata[0]), .s0_wstrb(s_wstrb[0]), .s0_wvalid(s_wvalid[0]), .s0_wready(1'b1),
        .s0_bresp(2'b00), .s0_bvalid(s_bvalid[0]), .s0_bready(s_bready[0]),
        .s0_araddr(s_araddr[0]), .s0_arvalid(s_arvalid[0]), .s0_arready(1'b1),
        .s0_rdata(s_rdata[0]), .s0_rresp(2'b00), .s0_rvalid(s_rvalid[0]), .s0_rready(s_rready[0]),
        .s1_awaddr(s_awaddr[1]), .s1_awvalid(s_awvalid[1]), .s1_awready(1'b1),
        .s1_wdata(s_wdata[1]), .s1_wstrb(s_wstrb[1]), .s1_wvalid(s_wvalid[1]), .s1_wready(1'b1),
        .s1_bresp(2'b00), .s1_bvalid(s_bvalid[1]), .s1_bready(s_bready[1]),
        .s1_araddr(s_araddr[1]), .s1_arvalid(s_arvalid[1]), .s1_arready(1'b1),
        .s1_rdata(s_rdata[1]), .s1_rresp(2'b00), .s1_rvalid(s_rvalid[1]), .s1_rready(s_rready[1])
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic int idx(input logic [31:0] a);
        return int'(a[5:2]);
    endfunction

    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int j = 0; j < 2; j++) begin
                s_bvalid[j] <= 1'b0;
                s_rvalid[j] <= 1'b0;
                s_rdata[j]  <= '0;
                aw_got[j]   <= 1'b0;
                w_got[j]    <= 1'b0;
                aw_a[j]     <= '0;
                w_d[j]      <= '0;
            end
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (s_bvalid[j] && s_bready[j]) s_bvalid[j] <= 1'b0;
                if ((s_awvalid[j] || aw_got[j]) && (s_wvalid[j] || w_got[j])) begin
                    mem[j][idx(s_awvalid[j] ? s_awaddr[j] : aw_a[j])] <= s_wvalid[j] ? s_wdata[j] : w_d[j];
                    s_bvalid[j] <= 1'b1;
                    aw_got[j]   <= 1'b0;
                    w_got[j]    <= 1'b0;
                end else begin
                    if (s_awvalid[j]) begin aw_got[j] <= 1'b1; aw_a[j] <= s_awaddr[j]; end
                    if (s_wvalid[j]) begin w_got[j] <= 1'b1; w_d[j] <= s_wdata[j]; end
                end
                if (s_rvalid[j] && s_rready[j]) s_rvalid[j] <= 1'b0;
                if (s_arvalid[j]) begin
                    s_rvalid[j] <= 1'b1;
                    s_rdata[j]  <= mem[j][idx(s_araddr[j])];
                end
            end
        end
    end

    always @(posedge aclk) begin
        if (!areset) begin
            for (int j = 0; j < 2; j++) begin
                if (s_awvalid[j]) begin aw_cnt[j] <= aw_cnt[j] + 1; last_aw[j] <= s_awaddr[j]; end
                if (s_wvalid[j]) begin w_cnt[j] <= w_cnt[j] + 1; last_wd[j] <= s_wdata[j]; end
                if (s_arvalid[j]) ar_cnt[j] <= ar_cnt[j] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic wr(input int i, input logic [31:0] a, input logic [31:0] d,
                      output logic [1:0] resp, output int cyc);
        logic ah, wh;
        @(negedge aclk);
        m_awaddr[i] = a; m_wdata[i] = d; m_wstrb[i] = 4'hF;
        m_awvalid[i] = 1'b1; m_wvalid[i] = 1'b1; m_bready[i] = 1'b1;
        cyc = 0; resp = 2'b01;
        while ((m_awvalid[i] || m_wvalid[i]) && cyc < 20) begin
            #1; ah = m_awready[i]; wh = m_wready[i];
            @(negedge aclk); cyc++;
            if (ah) m_awvalid[i] = 1'b0;
            if (wh) m_wvalid[i] = 1'b0;
        end
        while (cyc < 40) begin
            #1;
            if (m_bvalid[i]) begin resp = m_bresp[i]; @(negedge aclk); cyc++; break; end
            @(negedge aclk); cyc++;
        end
        m_awvalid[i] = 1'b0; m_wvalid[i] = 1'b0; m_bready[i] = 1'b0;
    endtask

    task automatic rd(input int i, input logic [31:0] a,
                      output logic [31:0] data, output logic [1:0] resp, output int cyc);
        logic ah;
        @(negedge aclk);
        m_araddr[i] = a; m_arvalid[i] = 1'b1; m_rready[i] = 1'b1;
        cyc = 0; resp = 2'b01; data = 32'hBAD0_BAD0;
        while (m_arvalid[i] && cyc < 20) begin
            #1; ah = m_arready[i];
            @(negedge aclk); cyc++;
            if (ah) m_arvalid[i] = 1'b0;
        end
        while (cyc < 40) begin
            #1;
            if (m_rvalid[i]) begin data = m_rdata[i]; resp = m_rresp[i]; @(negedge aclk); cyc++; break; end
            @(negedge aclk); cyc++;
        end
        m_arvalid[i] = 1'b0; m_rready[i] = 1'b0;
    endtask

    initial begin
        logic [1:0]  r0, r1;
        logic [31:0] d0, d1;
        int          c0, c1, base;
        logic        bseen;
        areset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            m_awaddr[i] = '0; m_wdata[i] = '0; m_wstrb[i] = '0; m_araddr[i] = '0;
            m_awvalid[i] = 1'b0; m_wvalid[i] = 1'b0; m_bready[i] = 1'b0;
            m_arvalid[i] = 1'b0; m_rready[i] = 1'b0;
        end
        repeat (2) @(negedge aclk);
        check("rst_m_ctl", 32'({m_awready[0], m_wready[0], m_bvalid[0], m_arready[0], m_rvalid[0],
                                m_awready[1], m_wready[1], m_bvalid[1], m_arready[1], m_rvalid[1]}), 32'd0);
        check("rst_s_ctl", 32'({s_awvalid[0], s_wvalid[0], s_bready[0], s_arvalid[0], s_rready[0],
                                s_awvalid[1], s_wvalid[1], s_bready[1], s_arvalid[1], s_rready[1]}), 32'd0);
        check("rst_data", m_rdata[0] | m_rdata[1] | s_awaddr[0] | s_wdata[1] | 32'({m_bresp[0], m_rresp[1]}), 32'd0);
        areset = 1'b0;

        fork
            wr(0, 32'h40, 32'h1111_1111, r0, c0);
            wr(1, 32'h44, 32'h2222_2222, r1, c1);
        join
        check("tieA_m0_resp", 32'(r0), 32'd0);
        check("tieA_m1_resp", 32'(r1), 32'd0);
        check("tieA_m0_cyc", c0, 3);
        check("tieA_m1_cyc", c1, 6);

        base = aw_cnt[1] + w_cnt[1];
        wr(0, 32'h10, 32'hDEAD_BEEF, r0, c0);
        check("w0_resp", 32'(r0), 32'd0);
        check("w0_cyc", c0, 3);
        check("w0_s0_awaddr", last_aw[0], 32'h10);
        check("w0_s0_wdata", last_wd[0], 32'hDEAD_BEEF);
        check("w0_s1_idle", aw_cnt[1] + w_cnt[1], base);

        fork
            wr(0, 32'h48, 32'h3333_3333, r0, c0);
            wr(1, 32'h4C, 32'h4444_4444, r1, c1);
        join
        check("tieB_m1_cyc", c1, 3);
        check("tieB_m0_cyc", c0, 6);
        check("tieB_resp", 32'({r0, r1}), 32'd0);

        rd(0, 32'h40, d0, r0, c0);
        check("rb_40", d0, 32'h1111_1111);
        rd(1, 32'h44, d1, r1, c1);
        check("rb_44", d1, 32'h2222_2222);
        rd(1, 32'h48, d1, r1, c1);
        check("rb_48", d1, 32'h3333_3333);
        rd(0, 32'h4C, d0, r0, c0);
        check("rb_4c", d0, 32'h4444_4444);

        wr(1, 32'h1004, 32'h1234_5678, r1, c1);
        check("w1_resp", 32'(r1), 32'd0);
        check("w1_s1_awaddr", last_aw[1], 32'h1004);
        base = ar_cnt[1];
        rd(1, 32'h1004, d1, r1, c1);
        check("r1_data", d1, 32'h1234_5678);
        check("r1_resp", 32'(r1), 32'd0);
        check("r1_cyc", c1, 3);
        check("r1_s1_ar", ar_cnt[1] - base, 1);

        base = ar_cnt[0] + ar_cnt[1];
        rd(0, 32'h3000, d0, r0, c0);
        check("rmiss_resp", 32'(r0), 32'd3);
        check("rmiss_data", d0, 32'd0);
        check("rmiss_cyc", c0, 3);
        check("rmiss_no_slave", ar_cnt[0] + ar_cnt[1], base);

        base = aw_cnt[0] + aw_cnt[1] + w_cnt[0] + w_cnt[1];
        wr(1, 32'h2000, 32'h5555_5555, r1, c1);
        check("wmiss_resp", 32'(r1), 32'd3);
        check("wmiss_cyc", c1, 3);
        check("wmiss_no_slave", aw_cnt[0] + aw_cnt[1] + w_cnt[0] + w_cnt[1], base);

        fork
            wr(0, 32'h8, 32'hA5A5_A5A5, r0, c0);
            rd(1, 32'h1004, d1, r1, c1);
        join
        check("conc_w_cyc", c0, 3);
        check("conc_r_cyc", c1, 3);
        check("conc_r_data", d1, 32'h1234_5678);
        check("conc_resp", 32'({r0, r1}), 32'd0);
        rd(1, 32'h8, d1, r1, c1);
        check("conc_rb", d1, 32'hA5A5_A5A5);

        @(negedge aclk);
        m_awaddr[0] = 32'h20; m_wdata[0] = 32'hCAFE_F00D; m_wstrb[0] = 4'hF;
        m_awvalid[0] = 1'b1; m_wvalid[0] = 1'b1; m_bready[0] = 1'b1;
        base = aw_cnt[0];
        @(negedge aclk);
        #1;
        check("mid_fwd_awv", 32'(s_awvalid[0]), 32'd1);
        #1 areset = 1'b1;
        #1;
        check("mid_rst_valids", 32'({s_awvalid[0], s_wvalid[0], s_awvalid[1], s_wvalid[1]}), 32'd0);
        @(negedge aclk);
        areset = 1'b0;
        m_awvalid[0] = 1'b0; m_wvalid[0] = 1'b0;
        bseen = 1'b0;
        repeat (4) begin
            #1 bseen = bseen | m_bvalid[0];
            @(negedge aclk);
        end
        m_bready[0] = 1'b0;
        check("mid_no_b", 32'(bseen), 32'd0);
        check("mid_no_aw", aw_cnt[0], base);

        wr(0, 32'h24, 32'h0BAD_CAFE, r0, c0);
        check("post_rst_resp", 32'(r0), 32'd0);
        check("post_rst_cyc", c0, 3);
        rd(0, 32'h24, d0, r0, c0);
        check("post_rst_rb", d0, 32'h0BAD_CAFE);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
